// File: rtl/timer.sv
// timer: memory-mapped 32-bit up/down counter with a 16-bit prescaler.
// A data write loads the count; a command write sets run/clear/dir/prescaler.
module timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        chipSelect,
    input  logic        write,
    input  logic        writeCommand,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut
);
    logic [31:0] counter;
    logic        run;
    logic        dir;
    logic [15:0] prescaler;
    logic [15:0] prescCnt;
    logic        dataWr;
    logic        cmdWr;
    logic        anyWr;
    logic        tick;
    logic        unusedBits;

    assign dataWr     = chipSelect & write;
    assign cmdWr      = chipSelect & writeCommand;
    assign anyWr      = dataWr | cmdWr;
    // Any bus write freezes counting for that cycle and restarts the prescaler phase.
    assign tick       = run & ~anyWr & (prescCnt == prescaler);
    assign unusedBits = ^dataIn[15:3];
    assign dataOut    = counter;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter   <= '0;
            run       <= 1'b0;
            dir       <= 1'b0;
            prescaler <= '0;
            prescCnt  <= '0;
        end else begin
            counter  <= (cmdWr & dataIn[1]) ? '0 : dataWr ? dataIn :
                        tick ? (dir ? counter - 32'd1 : counter + 32'd1) : counter;
            prescCnt <= (anyWr | tick) ? '0 : run ? prescCnt + 16'd1 : prescCnt;
            if (cmdWr) begin
                run       <= dataIn[0];
                dir       <= dataIn[2];
                prescaler <= dataIn[31:16];
            end
        end
    end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed and randomized checks of timer against an arithmetic reference model.
module tb_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        chipSelect = 1'b0;
    logic        write = 1'b0;
    logic        writeCommand = 1'b0;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;

    int checks = 0;
    int fails  = 0;

    // Model: count = base +/- floor(enabledCycles / (P+1)), rebased on every write.
    logic [31:0] mBase = '0;
    int unsigned mEn   = 0;
    logic        mRun  = 1'b0;
    logic        mDir  = 1'b0;
    logic [15:0] mP    = '0;

    timer dut (
        .clk(clk), .rst(rst), .chipSelect(chipSelect), .write(write),
        .writeCommand(writeCommand), .dataIn(dataIn), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelVal();
        logic [31:0] s;
        s = 32'(mEn / (32'(mP) + 32'd1));
        return mDir ? mBase - s : mBase + s;
    endfunction

    task automatic modelReset();
        mBase = '0; mEn = 0; mRun = 1'b0; mDir = 1'b0; mP = '0;
    endtask

    task automatic cyc(input logic cs, input logic w, input logic wc, input logic [31:0] d);
        logic [31:0] cur;
        chipSelect = cs; write = w; writeCommand = wc; dataIn = d;
        @(posedge clk);
        if (cs && (w || wc)) begin
            cur   = modelVal();
            mBase = (cs && w) ? d : cur;
            if (wc) begin
                mRun = d[0]; mDir = d[2]; mP = d[31:16];
                if (d[1]) mBase = '0;
            end
            mEn = 0;
        end else if (mRun) begin
            mEn++;
        end
        #1;
        chipSelect = 1'b0; write = 1'b0; writeCommand = 1'b0; dataIn = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic check(input string tag);
        logic [31:0] e;
        e = modelVal();
        checks++;
        assert (dataOut === e) else begin
            fails++;
            $error("FAIL %s dataOut=%h expected=%h", tag, dataOut, e);
        end
    endtask

    task automatic checkConst(input string tag, input logic [31:0] e);
        checks++;
        assert (dataOut === e) else begin
            fails++;
            $error("FAIL %s dataOut=%h expected=%h", tag, dataOut, e);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 checkConst("reset_value", 32'h0);
        @(negedge clk) rst = 1'b1;

        // free-run up from clear, P=0
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0003);
        checkConst("freerun_n", 32'd0);
        idle(1);
        checkConst("freerun_n1", 32'd1);
        idle(9);
        checkConst("freerun_n10", 32'd10);
        check("freerun_model");

        // asynchronous reset mid-count
        #2 rst = 1'b0;
        #1 checkConst("async_reset", 32'h0);
        modelReset();
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check("post_reset_hold");
        end
        checkConst("post_reset_20", 32'h0);

        // prescaler P=4 after a clear
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0002);
        cyc(1'b1, 1'b0, 1'b1, 32'h0004_0001);
        idle(4);
        checkConst("presc_before_step", 32'd0);
        idle(1);
        checkConst("presc_first_step", 32'd1);
        idle(20);
        checkConst("presc_25", 32'd5);

        // wrap up
        cyc(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0001);
        checkConst("wrap_up_load", 32'hFFFF_FFFE);
        idle(1);
        checkConst("wrap_up_max", 32'hFFFF_FFFF);
        idle(1);
        checkConst("wrap_up_zero", 32'h0);

        // wrap down
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0001);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0005);
        idle(1);
        checkConst("wrap_dn_zero", 32'h0);
        idle(1);
        checkConst("wrap_dn_max", 32'hFFFF_FFFF);

        // chip-select gating on a stopped counter
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0000);
        cyc(1'b0, 1'b1, 1'b0, 32'h1234_5678);
        checkConst("cs_gated", 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0003);
        checkConst("cs_gated_cmd", 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        checkConst("cs_load", 32'h1234_5678);

        // held data write keeps reloading while running
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0001);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        checkConst("held_load", 32'h0000_0100);
        // both strobes: clear beats loaded value
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0ABB);
        checkConst("both_clear_wins", 32'h0);

        // stop and resume at 0x20
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0020);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0000);
        checkConst("stop_at_20", 32'h20);
        idle(10);
        checkConst("stop_hold_10", 32'h20);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0001);
        checkConst("resume_edge", 32'h20);
        idle(1);
        checkConst("resume_21", 32'h21);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        cs, w, wc;
            logic [31:0] d;
            cs = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 15) == 0);
            wc = ($urandom_range(0, 11) == 0);
            d  = wc ? {16'($urandom_range(0, 3)), 13'($urandom), 3'($urandom)} : $urandom;
            if (wc && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            cyc(cs, w, wc, d);
            check("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
